frequency_meter: RTL and testbench
==================================

FREQUENCY_METER -- requirements
Module: frequency_meter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- REFERENCE_CLOCK, 50_000_000, clk frequency in Hz (documentation and bench use only; no RTL effect).
- MAX_PERIOD, 1000, longest measurable period in clk cycles.
- N_BITS, Ceil_Log2(MAX_PERIOD+1), width of the period and high-time outputs.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; all logic on rising edge.
- reset, input, 1, synchronous, active-high.
- enable, input, 1, measurement enable.
- signal_in, input, 1, asynchronous signal under measurement.
- period, output, N_BITS, clk cycles between the last two rising edges of signal_in.
- high_time, output, N_BITS, clk cycles signal_in was high within that period.
- valid, output, 1, one-cycle pulse: period and high_time updated.
- timeout, output, 1, sticky: no rising edge within MAX_PERIOD cycles.
- measuring, output, 1, high while in state MEASURE.

Function
REQ-003 signal_in SHALL pass through a 2-flop synchronizer (s1, s2) plus one delay flop s3; edge = s2 & ~s3.
REQ-004 The FSM SHALL have two states: ARM (wait for first edge) and MEASURE (count between edges).
REQ-005 ARM, edge: SHALL go to MEASURE, load cnt=1 and hcnt=1, and not assert valid.
REQ-006 MEASURE, no edge: SHALL increment cnt by 1, and increment hcnt by 1 when s2=1.
REQ-007 MEASURE, edge: SHALL latch period<=cnt and high_time<=hcnt, pulse valid for exactly 1 cycle, clear timeout, reload cnt=1 and hcnt=1, and stay in MEASURE.
REQ-008 MEASURE, cnt==MAX_PERIOD and no edge: SHALL set timeout=1, go to ARM, hold period and high_time, and not assert valid.
REQ-009 An edge in the same cycle as cnt==MAX_PERIOD SHALL take priority: a valid measurement with period=MAX_PERIOD, no timeout.
REQ-010 enable=0 SHALL force ARM and clear cnt and hcnt; period, high_time and timeout hold; valid=0. It is evaluated before edge handling.
REQ-011 cnt and hcnt SHALL be N_BITS wide and never wrap; hcnt<=cnt always.
REQ-012 Latency: valid SHALL assert in the cycle after the 3rd rising clk edge that samples signal_in high (2 synchronizer stages plus 1 output register).
REQ-013 measuring SHALL be 1 exactly when state==MEASURE.
REQ-014 A constant signal_in (0 or 1) SHALL never produce valid.

Reset
REQ-015 With reset=1 at a clk edge, the block SHALL clear: state=ARM, s1=s2=s3=0, cnt=hcnt=0, period=0, high_time=0, valid=0, timeout=0, measuring=0.
REQ-016 Reset mid-measurement SHALL discard the partial count; the first edge after reset only arms the block.
REQ-017 reset SHALL take priority over enable and edge in the same cycle.

Verification (MAX_PERIOD=1000)
REQ-018 Bench scenarios, one per line: stimulus -> required response.
- Square wave, period 10, 5 high / 5 low, enable=1 -> first edge arms only; every later edge gives valid, period=10, high_time=5.
- Period 20 with 3 cycles high -> period=20, high_time=3; valid pulses exactly 1 cycle every 20 cycles.
- signal_in held low for 1200 cycles after arming -> timeout=1 when cnt reaches 1000, measuring=0; next two edges 8 cycles apart -> valid, period=8, timeout=0.
- Edges exactly 1000 cycles apart -> valid, period=1000, timeout stays 0.
- enable dropped mid-period, raised, then edges 10 cycles apart -> no valid while disabled; old period held; first edge after re-enable arms only; next gives period=10.
- reset=1 asserted mid-measure for 1 cycle -> all outputs 0 next cycle; a following 10-cycle square wave gives its first valid only on the 2nd edge, period=10.

Source files
------------

// File: rtl/frequency_meter.sv
// Period and high-time meter: counts clk cycles between successive synchronized
// rising edges of signal_in, with a sticky timeout when no edge arrives in time.
module frequency_meter #(
  parameter int unsigned REFERENCE_CLOCK = 50_000_000,
  parameter int unsigned MAX_PERIOD      = 1000,
  parameter int unsigned N_BITS          = $clog2(MAX_PERIOD + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              signal_in,
  output logic [N_BITS-1:0] period,
  output logic [N_BITS-1:0] high_time,
  output logic              valid,
  output logic              timeout,
  output logic              measuring
);

  typedef enum logic {ARM, MEASURE} state_t;

  localparam logic [N_BITS-1:0] MAX_CNT = N_BITS'(MAX_PERIOD);
  localparam logic [N_BITS-1:0] ONE     = N_BITS'(1);

  // REFERENCE_CLOCK only documents the clk rate; it is sanity-checked here so a
  // zero setting is caught at elaboration.
  if (REFERENCE_CLOCK == 0 || MAX_PERIOD == 0) begin : g_cfg_check
    $error("frequency_meter: REFERENCE_CLOCK and MAX_PERIOD must be non-zero");
  end

  state_t            state, state_next;
  logic              s1, s2, s3;
  logic              rise;
  logic [N_BITS-1:0] cnt, cnt_next;
  logic [N_BITS-1:0] hcnt, hcnt_next;
  logic [N_BITS-1:0] period_next, high_time_next;
  logic              valid_next, timeout_next;

  assign rise      = s2 & ~s3;
  assign measuring = (state == MEASURE);

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    hcnt_next      = hcnt;
    period_next    = period;
    high_time_next = high_time;
    valid_next     = 1'b0;
    timeout_next   = timeout;

    if (!enable) begin
      state_next = ARM;
      cnt_next   = '0;
      hcnt_next  = '0;
    end else begin
      case (state)
        ARM: begin
          if (rise) begin
            state_next = MEASURE;
            cnt_next   = ONE;
            hcnt_next  = ONE;
          end
        end
        MEASURE: begin
          // An edge landing on the last countable cycle is still a valid period.
          if (rise) begin
            period_next    = cnt;
            high_time_next = hcnt;
            valid_next     = 1'b1;
            timeout_next   = 1'b0;
            cnt_next       = ONE;
            hcnt_next      = ONE;
          end else if (cnt == MAX_CNT) begin
            timeout_next = 1'b1;
            state_next   = ARM;
          end else begin
            cnt_next = cnt + ONE;
            if (s2) hcnt_next = hcnt + ONE;
          end
        end
        default: state_next = ARM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARM;
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      cnt       <= '0;
      hcnt      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      s1        <= signal_in;
      s2        <= s1;
      s3        <= s2;
      state     <= state_next;
      cnt       <= cnt_next;
      hcnt      <= hcnt_next;
      period    <= period_next;
      high_time <= high_time_next;
      valid     <= valid_next;
      timeout   <= timeout_next;
    end
  end

endmodule

// File: tb/tb_frequency_meter.sv
// Bench for frequency_meter: edge-timestamp reference model plus scenario tasks.
module tb_frequency_meter;

  localparam int unsigned MAXP = 1000;
  localparam int unsigned NB   = $clog2(MAXP + 1);
  localparam int          SZ   = 16384;
  localparam int          VW   = 3 + 2 * NB;

  logic          clk = 1'b0;
  logic          reset, enable, signal_in;
  logic [NB-1:0] period, high_time;
  logic          valid, timeout, measuring;

  frequency_meter #(
    .REFERENCE_CLOCK(50_000_000),
    .MAX_PERIOD     (MAXP),
    .N_BITS         (NB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .signal_in(signal_in),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .timeout  (timeout),
    .measuring(measuring)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: timestamps of synchronized rising edges, sums over history.
  logic          hist [SZ];
  int            n = 0;
  int            rst_cyc = 0;
  int            last = 0;
  logic          m_meas = 1'b0, m_to = 1'b0, m_valid = 1'b0;
  logic [NB-1:0] m_per = '0, m_ht = '0;

  // signal_in as seen by the edge detector at clock k: two cycles late, zero
  // until two fresh samples have been taken after a reset.
  function automatic logic syn(input int k);
    if (k - 2 <= rst_cyc) return 1'b0;
    return hist[(k - 2) % SZ];
  endfunction

  always @(posedge clk) begin
    int s;
    n = n + 1;
    hist[n % SZ] = signal_in;
    m_valid = 1'b0;
    if (reset) begin
      m_meas = 1'b0; m_to = 1'b0; m_per = '0; m_ht = '0; rst_cyc = n;
    end else if (!enable) begin
      m_meas = 1'b0;
    end else if (syn(n) && !syn(n - 1)) begin
      if (m_meas) begin
        s = 0;
        for (int k = last; k < n; k++) s += int'(syn(k));
        m_per   = NB'(n - last);
        m_ht    = NB'(s);
        m_valid = 1'b1;
        m_to    = 1'b0;
      end
      m_meas = 1'b1;
      last   = n;
    end else if (m_meas && (n - last) == int'(MAXP)) begin
      m_to   = 1'b1;
      m_meas = 1'b0;
    end
  end

  // Per-cycle trace against the model plus observation recording.
  int            dev;
  int            dev_cyc;
  logic [VW-1:0] dev_act, dev_exp;
  int            nv, pv_cyc, gmin, gmax;
  logic [NB-1:0] vper, vht;
  logic          to_seen;

  task automatic clear_obs();
    dev = 0; nv = 0; pv_cyc = -1; gmin = 1 << 30; gmax = 0;
    vper = '0; vht = '0; to_seen = 1'b0;
  endtask

  task automatic tick(input logic s);
    logic [VW-1:0] a, e;
    @(negedge clk);
    a = {valid, timeout, measuring, period, high_time};
    e = {m_valid, m_to, m_meas, m_per, m_ht};
    if (a !== e) begin
      if (dev == 0) begin dev_cyc = n; dev_act = a; dev_exp = e; end
      dev++;
    end
    if (valid === 1'b1) begin
      nv++;
      if (pv_cyc >= 0) begin
        if (n - pv_cyc < gmin) gmin = n - pv_cyc;
        if (n - pv_cyc > gmax) gmax = n - pv_cyc;
      end
      pv_cyc = n; vper = period; vht = high_time;
    end
    if (timeout === 1'b1) to_seen = 1'b1;
    signal_in = s;
  endtask

  task automatic wave(input int p, input int h);
    for (int i = 0; i < p; i++) tick(i < h);
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1;
    tick(1'b0); tick(1'b0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0);
  endtask

  task automatic test_reset();
    clear_obs();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'($urandom_range(0, 1)));
    total++;
    if ({valid, timeout, measuring, period, high_time} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {valid, timeout, measuring, period, high_time});
    end
    reset = 1'b0;
    tick(1'b0); tick(1'b0);
    total++;
    if (dev !== 0) begin
      bad++;
      $display("FAIL reset_trace diffs=%0d first_cyc=%0d got=%h want=%h (need 0 diffs)", dev, dev_cyc, dev_act, dev_exp);
    end
  endtask

  task automatic test_square();
    do_reset(); clear_obs();
    for (int i = 0; i < 8; i++) wave(10, 5);
    total++;
    if (nv !== 7 || vper !== NB'(10) || vht !== NB'(5)) begin
      bad++;
      $display("FAIL square_10_5 got nv=%0d per=%0d ht=%0d want nv=7 per=10 ht=5", nv, vper, vht);
    end
    total++;
    if (dev !== 0) begin
      bad++;
      $display("FAIL square_trace diffs=%0d first_cyc=%0d got=%h want=%h (need 0 diffs)", dev, dev_cyc, dev_act, dev_exp);
    end
  endtask

  task automatic test_duty();
    do_reset(); clear_obs();
    for (int i = 0; i < 6; i++) wave(20, 3);
    total++;
    if (nv !== 5 || vper !== NB'(20) || vht !== NB'(3) || gmin !== 20 || gmax !== 20) begin
      bad++;
      $display("FAIL duty_20_3 got nv=%0d per=%0d ht=%0d gap=%0d..%0d want nv=5 per=20 ht=3 gap=20..20",
               nv, vper, vht, gmin, gmax);
    end
    total++;
    if (dev !== 0) begin
      bad++;
      $display("FAIL duty_trace diffs=%0d first_cyc=%0d got=%h want=%h (need 0 diffs)", dev, dev_cyc, dev_act, dev_exp);
    end
  endtask

  task automatic test_constant();
    do_reset(); clear_obs();
    for (int i = 0; i < 60; i++) tick(1'b1);
    for (int i = 0; i < 60; i++) tick(1'b0);
    total++;
    if (nv !== 0 || dev !== 0) begin
      bad++;
      $display("FAIL constant_input got nv=%0d diffs=%0d want nv=0 diffs=0", nv, dev);
    end
  endtask

  task automatic test_timeout();
    do_reset(); clear_obs();
    wave(8, 4); wave(8, 4);
    for (int i = 0; i < 1200; i++) tick(1'b0);
    total++;
    if (timeout !== 1'b1 || measuring !== 1'b0 || period !== NB'(8) || high_time !== NB'(4)) begin
      bad++;
      $display("FAIL timeout_set got to=%b meas=%b per=%0d ht=%0d want to=1 meas=0 per=8 ht=4",
               timeout, measuring, period, high_time);
    end
    total++;
    if (dev !== 0) begin
      bad++;
      $display("FAIL timeout_trace diffs=%0d first_cyc=%0d got=%h want=%h (need 0 diffs)", dev, dev_cyc, dev_act, dev_exp);
    end
    clear_obs();
    wave(8, 4); tick(1'b1);
    for (int i = 0; i < 10; i++) tick(1'b0);
    total++;
    if (nv !== 1 || vper !== NB'(8) || timeout !== 1'b0) begin
      bad++;
      $display("FAIL timeout_recover got nv=%0d per=%0d to=%b want nv=1 per=8 to=0", nv, vper, timeout);
    end
  endtask

  task automatic test_max_period();
    do_reset(); clear_obs();
    wave(1000, 500); wave(1000, 500); tick(1'b1);
    for (int i = 0; i < 5; i++) tick(1'b0);
    total++;
    if (nv !== 2 || vper !== NB'(1000) || vht !== NB'(500) || to_seen !== 1'b0) begin
      bad++;
      $display("FAIL max_period got nv=%0d per=%0d ht=%0d to_seen=%b want nv=2 per=1000 ht=500 to_seen=0",
               nv, vper, vht, to_seen);
    end
    total++;
    if (dev !== 0) begin
      bad++;
      $display("FAIL max_trace diffs=%0d first_cyc=%0d got=%h want=%h (need 0 diffs)", dev, dev_cyc, dev_act, dev_exp);
    end
  endtask

  task automatic test_enable();
    do_reset(); clear_obs();
    for (int i = 0; i < 3; i++) wave(12, 4);
    enable = 1'b0;
    clear_obs();
    wave(10, 5); wave(10, 5);
    total++;
    if (nv !== 0 || period !== NB'(12) || high_time !== NB'(4) || measuring !== 1'b0) begin
      bad++;
      $display("FAIL enable_low got nv=%0d per=%0d ht=%0d meas=%b want nv=0 per=12 ht=4 meas=0",
               nv, period, high_time, measuring);
    end
    enable = 1'b1;
    clear_obs();
    for (int i = 0; i < 3; i++) wave(10, 5);
    for (int i = 0; i < 5; i++) tick(1'b0);
    total++;
    if (nv !== 2 || vper !== NB'(10) || vht !== NB'(5) || dev !== 0) begin
      bad++;
      $display("FAIL enable_resume got nv=%0d per=%0d ht=%0d diffs=%0d want nv=2 per=10 ht=5 diffs=0",
               nv, vper, vht, dev);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(); clear_obs();
    wave(10, 5); wave(10, 5);
    tick(1'b1); tick(1'b1); tick(1'b0);
    reset = 1'b1;
    tick(1'b0);
    total++;
    if ({valid, timeout, measuring, period, high_time} !== '0) begin
      bad++;
      $display("FAIL reset_mid_clear got=%h want=0", {valid, timeout, measuring, period, high_time});
    end
    reset = 1'b0;
    clear_obs();
    for (int i = 0; i < 3; i++) wave(10, 5);
    for (int i = 0; i < 5; i++) tick(1'b0);
    total++;
    if (nv !== 2 || vper !== NB'(10) || dev !== 0) begin
      bad++;
      $display("FAIL reset_mid_rearm got nv=%0d per=%0d diffs=%0d want nv=2 per=10 diffs=0", nv, vper, dev);
    end
  endtask

  task automatic test_random();
    int p, h;
    do_reset(); clear_obs();
    for (int i = 0; i < 20; i++) begin
      p = int'($urandom_range(4, 60));
      h = int'($urandom_range(1, p - 1));
      wave(p, h);
    end
    tick(1'b1);
    for (int i = 0; i < 5; i++) tick(1'b0);
    total++;
    if (nv !== 20) begin
      bad++;
      $display("FAIL random_count got nv=%0d want 20", nv);
    end
    total++;
    if (dev !== 0) begin
      bad++;
      $display("FAIL random_trace diffs=%0d first_cyc=%0d got=%h want=%h (need 0 diffs)", dev, dev_cyc, dev_act, dev_exp);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; signal_in = 1'b0;
    test_reset();
    test_square();
    test_duty();
    test_constant();
    test_timeout();
    test_max_period();
    test_enable();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
